// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-add slice (two half-adder stages plus a
// carry flip-flop) time-shared LSB-first over WIDTH cycles behind valid/ready handshakes.
module bit_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic s1, c1, s_bit, c2, co;

    // Full-add slice: first half adder on the operand bits, second on the carry.
    always_comb begin
        s1    = a_sr_q[0] ^ b_sr_q[0];
        c1    = a_sr_q[0] & b_sr_q[0];
        s_bit = s1 ^ carry_q;
        c2    = s1 & carry_q;
        co    = c1 | c2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        sum_sr_q   <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr_q <= {s_bit, sum_sr_q[WIDTH-1:1]};
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    carry_q  <= co;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // carry_q here is the carry into the MSB slice
                        ovf_q       <= carry_q ^ co;
                        cout_q      <= co;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_sr_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl: an 8-bit instance for handshake and
// timing scenarios, and a 4-bit instance swept exhaustively.
module tb_bit_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, out_valid8, out_ready8 = 1'b0, cout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b0, cout4, ovf4;
    logic [3:0] a4 = '0, b4 = '0, sum4;

    bit_serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    bit_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // Called #1 after an edge with dut8 idle; returns the held result and the
    // number of edges from the accept edge to out_valid.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          output logic [7:0] s, output logic co, output logic ov, output int lat);
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid8 && lat < 100);
        s = sum8; co = cout8; ov = ovf8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                          output logic [3:0] s, output logic co, output logic ov, output int lat);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = ~ta; b4 = ~tb; cin4 = ~tc;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid4 && lat < 100);
        s = sum4; co = cout4; ov = ovf4;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out_valid=%b sum=%h cout=%b ovf=%b required 0 00 0 0",
                     out_valid8, sum8, cout8, ovf8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b sum=%h required 1 0 00",
                     in_ready8, out_valid8, sum8);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [7] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h12, 8'hFF, 8'hA5};
        logic [7:0] vb [7] = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h34, 8'hFF, 8'h5A};
        logic       vc [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [7:0] es [7] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h47, 8'hFF, 8'h00};
        logic       ec [7] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        logic       eo [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        logic [7:0] s;
        logic       co, ov;
        int         lat;
        for (int i = 0; i < 7; i++) begin
            do_op8(va[i], vb[i], vc[i], s, co, ov, lat);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d cycles required 8", i, lat);
            end
            checks++;
            if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                errors++;
                $display("FAIL vec%0d_result: a=%h b=%h cin=%b got sum=%h cout=%b ovf=%b required %h %b %b",
                         i, va[i], vb[i], vc[i], s, co, ov, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'h11; b8 = 8'h22;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_valid8 !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: out_valid=%b required 1", out_valid8);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || sum8 !== 8'h80 ||
                cout8 !== 1'b0 || ovf8 !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 80 0 1",
                         i, out_valid8, in_ready8, sum8, cout8, ovf8);
            end
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid8, in_ready8);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_accept: in_ready=%b out_valid=%b required 1 0", in_ready8, out_valid8);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic       co, ov;
        int         lat;
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || sum8 !== 8'h00 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b sum=%h in_ready=%b required 0 00 1",
                     out_valid8, sum8, in_ready8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op8(8'h12, 8'h34, 1'b1, s, co, ov, lat);
        checks++;
        if (s !== 8'h47 || co !== 1'b0 || ov !== 1'b0 || lat !== 8) begin
            errors++;
            $display("FAIL post_reset_op: sum=%h cout=%b ovf=%b lat=%0d required 47 0 0 8", s, co, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'h01, 8'hC8, 8'h40};
        logic [7:0] vb [3] = '{8'h02, 8'h64, 8'h40};
        logic       vc [3] = '{1'b1,  1'b0,  1'b0};
        logic [7:0] es [3] = '{8'h04, 8'h2C, 8'h80};
        logic       ec [3] = '{1'b0,  1'b1,  1'b0};
        logic       eo [3] = '{1'b0,  1'b0,  1'b1};
        int j = 1, k = 0, last = -1;
        a8 = va[0]; b8 = vb[0]; cin8 = vc[0]; in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (out_valid8 === 1'b1 && k < 3) begin
                checks++;
                if (sum8 !== es[k] || cout8 !== ec[k] || ovf8 !== eo[k]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b required %h %b %b",
                             k, sum8, cout8, ovf8, es[k], ec[k], eo[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc - last !== 10) begin
                        errors++;
                        $display("FAIL b2b_period%0d: got %0d cycles required 10", k, cyc - last);
                    end
                end
                last = cyc;
                k++;
            end
            if (in_ready8 === 1'b1) begin
                if (j < 3) begin
                    a8 = va[j]; b8 = vb[j]; cin8 = vc[j];
                    j++;
                end else begin
                    in_valid8 = 1'b0;
                end
            end
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 3", k);
        end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] s;
        logic       co, ov, exp_ov;
        int         lat, sa, sb, ssum, usum;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    do_op4(4'(ia), 4'(ib), ic[0], s, co, ov, lat);
                    usum   = ia + ib + ic;
                    sa     = (ia >= 8) ? ia - 16 : ia;
                    sb     = (ib >= 8) ? ib - 16 : ib;
                    ssum   = sa + sb + ic;
                    exp_ov = (ssum > 7 || ssum < -8);
                    checks++;
                    if ({co, s} !== 5'(usum) || ov !== exp_ov || lat !== 4) begin
                        errors++;
                        $display("FAIL w4_%0d_%0d_%0d: cout,sum=%b_%h ovf=%b lat=%0d required %h ovf=%b lat=4",
                                 ia, ib, ic, co, s, ov, lat, 5'(usum), exp_ov);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
